// File: rtl/en_seq_gen.sv
// en_seq_gen: thermometer-sequenced enable channels, each stepped after a per-channel RTC tick delay
module en_seq_gen #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk_i,
    input  logic                    arst_ni,
    input  logic                    rtc_i,
    input  logic                    en_i,
    input  logic [NUM_CH*CNT_W-1:0] dly_i,
    output logic [NUM_CH-1:0]       en_o,
    output logic                    busy_o,
    output logic                    done_o
);
    localparam int IW = $clog2(NUM_CH + 1);
    localparam logic [1:0] OFF = 2'd0, UP = 2'd1, ON = 2'd2, DOWN = 2'd3;

    logic [SYNC_STAGES-1:0] sync_q, vld_q;
    logic                   low_q, tick;
    logic [1:0]             state_q, state_d;
    logic [NUM_CH-1:0]      en_q, en_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, dly_sel;
    logic [IW-1:0]          n, nn, ld_ch;
    logic                   up_sw, dn_sw, load;

    // rtc synchronizer; vld_q marks when the chain holds real post-reset samples
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            sync_q <= '0;
            vld_q  <= '0;
            low_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rtc_i};
            vld_q  <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            low_q  <= vld_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-1];
        end
    end

    // a tick needs a genuinely observed low, so rtc held high through reset never counts
    assign tick = low_q & sync_q[SYNC_STAGES-1];

    // number of channels currently on
    always_comb begin
        n = '0;
        for (int k = 0; k < NUM_CH; k++) n = n + IW'(en_q[k]);
    end

    // channel switching and direction; a switch completes before any direction change
    always_comb begin
        up_sw   = state_q == UP && cnt_q == '0;
        dn_sw   = state_q == DOWN && cnt_q == '0 && n != '0;
        en_d    = up_sw ? ((en_q << 1) | NUM_CH'(1)) : dn_sw ? (en_q >> 1) : en_q;
        nn      = n + IW'(up_sw) - IW'(dn_sw);
        state_d = state_q == OFF ? (en_i ? UP : OFF) :
                  state_q == UP  ? (!en_i ? DOWN : nn == IW'(NUM_CH) ? ON : UP) :
                  state_q == ON  ? (en_i ? ON : DOWN) :
                                   (en_i ? UP : nn == '0 ? OFF : DOWN);
        load    = (state_d == UP || state_d == DOWN) && (state_d != state_q || up_sw || dn_sw);
        ld_ch   = state_d == UP ? nn : nn - IW'(1);
    end

    // delay of the channel to be loaded; an out-of-range index selects nothing
    always_comb begin
        dly_sel = '0;
        for (int k = 0; k < NUM_CH; k++)
            if (IW'(k) == ld_ch) dly_sel = dly_i[k*CNT_W +: CNT_W];
    end

    assign cnt_d = load ? dly_sel : (tick && cnt_q != '0 && busy_o) ? cnt_q - CNT_W'(1) : cnt_q;

    // sequencer state, channel enables and delay counter
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= OFF;
            en_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            cnt_q   <= cnt_d;
        end
    end

    assign en_o   = en_q;
    assign busy_o = state_q == UP || state_q == DOWN;
    assign done_o = state_q == ON;
endmodule
